// File: rtl/edge_capture.sv
// Multi-channel edge capture: optional synchroniser, per-channel glitch filter,
// runtime edge-mode match, sticky event flags and a combined interrupt.
module edge_capture #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic [2*WIDTH-1:0] edge_sel,
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   sticky,
  output logic               irq
);

  // A one-cycle filter still needs a legal (unused) counter bit.
  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = din;
  end else begin : g_sync
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= din;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic             irq_q;

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          // Candidate has persisted long enough: accept it and match the new level.
          level_d[i] = s[i];
          case (edge_sel[2*i +: 2])
            2'b01:   pulse_d[i] = s[i];
            2'b10:   pulse_d[i] = ~s[i];
            2'b11:   pulse_d[i] = 1'b1;
            default: pulse_d[i] = 1'b0;
          endcase
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    // A new event beats a simultaneous clear.
    sticky_d = (sticky_q & ~clr) | pulse_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      irq_q    <= |sticky_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level  = level_q;
  assign pulse  = pulse_q;
  assign sticky = sticky_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_edge_capture.sv
// Bench for edge_capture: directed vector table, corner-case sequences and a
// randomized run compared every cycle against a sliding-window reference model.
module tb_edge_capture;

  localparam int unsigned W  = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned FL = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   din, clr, level, pulse, sticky;
  logic [2*W-1:0] edge_sel;
  logic           irq;

  logic [1:0] din2, clr2, level2, pulse2, sticky2;
  logic [3:0] sel2;
  logic       irq2;

  always #5 clk = ~clk;

  edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .edge_sel (edge_sel),
    .clr      (clr),
    .level    (level),
    .pulse    (pulse),
    .sticky   (sticky),
    .irq      (irq)
  );

  edge_capture #(.WIDTH(2), .SYNC_STAGES(0), .FILTER_LEN(1)) dut_fast (
    .clk      (clk),
    .rst      (rst),
    .din      (din2),
    .edge_sel (sel2),
    .clr      (clr2),
    .level    (level2),
    .pulse    (pulse2),
    .sticky   (sticky2),
    .irq      (irq2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of sampled din words; a channel flips when the last
  // FL filter-visible samples all disagree with its current level.
  logic [W-1:0] hist [$];
  logic [W-1:0] m_level, m_pulse, m_sticky;
  logic         m_irq;

  function automatic void model_clear();
    hist.delete();
    m_level  = '0;
    m_pulse  = '0;
    m_sticky = '0;
    m_irq    = 1'b0;
  endfunction

  function automatic logic s_at(int i, int k);
    int idx;
    idx = hist.size() - 1 - int'(SS) - k;
    if (idx < 0) return 1'b0;
    return hist[idx][i];
  endfunction

  function automatic void model_step();
    logic [W-1:0] nl, np;
    bit           flip;
    hist.push_back(din);
    if (hist.size() > SS + FL + 4) void'(hist.pop_front());
    nl = m_level;
    np = '0;
    for (int i = 0; i < W; i++) begin
      flip = 1'b1;
      for (int k = 0; k < FL; k++) if (s_at(i, k) == m_level[i]) flip = 1'b0;
      if (flip) begin
        nl[i] = ~m_level[i];
        // Mode bit 0 enables rising events, bit 1 falling events.
        np[i] = nl[i] ? edge_sel[2*i] : edge_sel[2*i+1];
      end
    end
    m_level  = nl;
    m_pulse  = np;
    m_sticky = (m_sticky & ~clr) | np;
    m_irq    = |m_sticky;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else model_step();
    #1;
    check("model_level", 32'(level), 32'(m_level));
    check("model_pulse", 32'(pulse), 32'(m_pulse));
    check("model_sticky", 32'(sticky), 32'(m_sticky));
    check("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] clr;
    logic         lvl0;
    logic         pul0;
    logic         stk0;
    logic         irq;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int acc, cnt, first, last;
    logic prev;

    tbl = '{
      '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1},
      '{8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
      '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
      '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
      '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
      '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
      '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
      '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
      '{8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    rst = 1'b1;
    din = '0; clr = '0; edge_sel = '0;
    din2 = '0; clr2 = '0; sel2 = '0;
    model_clear();
    #2;
    check("reset_level", 32'(level), 32'h0);
    check("reset_pulse", 32'(pulse), 32'h0);
    check("reset_sticky", 32'(sticky), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    #10;
    rst = 1'b0;

    // Channel 0 rising-only: rise, fall, clear.
    edge_sel = 16'h0001;
    for (int r = 0; r < 15; r++) begin
      din = tbl[r].din;
      clr = tbl[r].clr;
      tick();
      check($sformatf("tbl%0d_level", r), 32'(level), {31'b0, tbl[r].lvl0});
      check($sformatf("tbl%0d_pulse", r), 32'(pulse), {31'b0, tbl[r].pul0});
      check($sformatf("tbl%0d_sticky", r), 32'(sticky), {31'b0, tbl[r].stk0});
      check($sformatf("tbl%0d_irq", r), 32'(irq), {31'b0, tbl[r].irq});
    end
    clr = '0;

    // No sync, no filter: event visible right after the sampling edge.
    sel2 = 4'b0100;
    din2 = 2'b10;
    tick();
    check("fast_pulse", 32'(pulse2), 32'h2);
    check("fast_level", 32'(level2), 32'h2);
    check("fast_irq", 32'(irq2), 32'h1);
    tick();
    check("fast_pulse_width", 32'(pulse2), 32'h0);
    din2 = 2'b00;
    tick();
    check("fast_fall_level", 32'(level2), 32'h0);
    check("fast_fall_nopulse", 32'(pulse2), 32'h0);

    // Glitch shorter than the filter on ch3, then a long enough pulse.
    edge_sel = 16'h00C1;
    clr = '1; tick(); clr = '0;
    acc = 0;
    din[3] = 1'b1;
    for (int j = 0; j < 3; j++) begin tick(); acc += int'(pulse[3]); end
    din[3] = 1'b0;
    for (int j = 0; j < 10; j++) begin tick(); acc += int'(pulse[3]); end
    check("glitch_nopulse", 32'(acc), 32'h0);
    check("glitch_level", 32'(level[3]), 32'h0);
    check("glitch_sticky", 32'(sticky[3]), 32'h0);
    acc = 0;
    din[3] = 1'b1;
    for (int j = 0; j < 10; j++) begin tick(); acc += int'(pulse[3]); end
    check("held_onepulse", 32'(acc), 32'h1);
    check("held_level", 32'(level[3]), 32'h1);
    check("held_sticky", 32'(sticky[3]), 32'h1);

    // Sticky on ch2: clear coinciding with a new event loses to the event.
    din = '0; edge_sel = 16'h0010; clr = '1;
    ticks(8);
    clr = '0;
    din[2] = 1'b1; ticks(6);
    check("ch2_set", 32'(sticky[2]), 32'h1);
    din[2] = 1'b0; ticks(8);
    check("ch2_fall_level", 32'(level[2]), 32'h0);
    check("ch2_fall_keep", 32'(sticky[2]), 32'h1);
    din[2] = 1'b1; ticks(5);
    clr[2] = 1'b1; tick();
    check("ch2_collide_pulse", 32'(pulse[2]), 32'h1);
    check("ch2_collide_sticky", 32'(sticky[2]), 32'h1);
    tick();
    check("ch2_cleared", 32'(sticky[2]), 32'h0);
    check("ch2_irq_low", 32'(irq), 32'h0);
    clr = '0;

    // ch5 square wave, period 16, any-edge mode then off.
    din = '0; edge_sel = 16'h0C00; clr = '1; ticks(8); clr = '0;
    cnt = 0; last = -1;
    for (int t = 0; t < 64; t++) begin
      din[5] = ((t / 8) % 2) == 0;
      tick();
      if (pulse[5]) begin
        if (last >= 0) check("sq_spacing", 32'(t - last), 32'd8);
        last = t;
        cnt++;
      end
    end
    check("sq_count", 32'(cnt), 32'd8);
    edge_sel = '0; clr = '1; tick(); clr = '0;
    cnt = 0; acc = 0; prev = level[5];
    for (int t = 0; t < 64; t++) begin
      din[5] = ((t / 8) % 2) == 0;
      tick();
      acc += int'(pulse[5]);
      if (level[5] != prev) cnt++;
      prev = level[5];
    end
    check("off_nopulse", 32'(acc), 32'h0);
    check("off_toggles", 32'(cnt), 32'd8);
    check("off_sticky", 32'(sticky[5]), 32'h0);

    // Reset with a candidate pending on ch4.
    din = 8'h01; edge_sel = 16'h0101; ticks(8);
    din[4] = 1'b1; ticks(4);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_mid_level", 32'(level), 32'h0);
    check("rst_mid_pulse", 32'(pulse), 32'h0);
    check("rst_mid_sticky", 32'(sticky), 32'h0);
    check("rst_mid_irq", 32'(irq), 32'h0);
    ticks(2);
    rst = 1'b0;
    first = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (pulse[4] && first < 0) first = t;
    end
    check("rst_release_latency", 32'(first), 32'd6);

    // Randomized run against the model.
    for (int t = 0; t < 600; t++) begin
      if (t % 50 == 0) edge_sel = 16'($urandom);
      for (int i = 0; i < W; i++) if ($urandom_range(7) == 0) din[i] = ~din[i];
      clr = 8'($urandom & $urandom & $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
